// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory read port, decode handshake,
// and the redirect/halt controls coming back from decode.
interface fetch_unit_if #(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_SIZE = 8
);
    logic [ADDR_SIZE-1:0]   imem_addr;
    logic                   imem_en;
    logic [2*WORD_SIZE-1:0] imem_data;
    logic [2*WORD_SIZE-1:0] inst;
    logic [ADDR_SIZE-1:0]   inst_pc;
    logic                   inst_valid;
    logic                   inst_ready;
    logic                   redirect;
    logic [ADDR_SIZE-1:0]   redirect_pc;
    logic                   halt;
    logic                   halted;

    modport master (
        output imem_addr, imem_en, inst, inst_pc, inst_valid, halted,
        input  imem_data, inst_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  imem_addr, imem_en, inst, inst_pc, inst_valid, halted,
        output imem_data, inst_ready, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads imem (1-cycle latency),
// buffers words in a 2-entry queue and hands them to decode.
module fetch_unit #(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_SIZE = 8,
    parameter logic [ADDR_SIZE-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    typedef logic [2*WORD_SIZE-1:0] word_t;
    typedef logic [ADDR_SIZE-1:0]   addr_t;
    typedef enum logic {RUN, HALTED} state_t;

    state_t     state, state_nx;
    addr_t      fetch_pc, inflight_pc;
    word_t      q_inst [2];
    addr_t      q_pc   [2];
    logic       head;
    logic [1:0] count;
    logic       inflight;
    logic       pop, issue, flush, push, tail;
    logic [2:0] occ;

    assign tail     = head ^ count[0];
    assign bus.inst    = q_inst[head];
    assign bus.inst_pc = q_pc[head];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        bus.imem_addr  = fetch_pc;
        bus.inst_valid = 1'b0;
        bus.halted     = (state == HALTED);
        pop   = 1'b0;
        flush = 1'b0;
        push  = 1'b0;
        issue = 1'b0;
        occ   = '0;
        unique case (state)
            RUN: begin
                bus.inst_valid = (count != 2'd0);
                pop   = bus.inst_valid & bus.inst_ready;
                occ   = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
                flush = bus.halt | bus.redirect;
                push  = inflight & ~flush;
                if (bus.halt) begin
                    state_nx = HALTED;
                end else if (bus.redirect) begin
                    issue         = 1'b1;
                    bus.imem_addr = bus.redirect_pc;
                end else begin
                    issue = (occ < 3'd2);
                end
            end
            HALTED: begin
                issue = 1'b0;
            end
        endcase
        // Combinational outputs must stay quiet while reset is held.
        if (rst) begin
            issue         = 1'b0;
            bus.imem_addr = fetch_pc;
        end
        bus.imem_en = issue;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            head        <= 1'b0;
            count       <= 2'd0;
            q_inst[0]   <= '0;
            q_inst[1]   <= '0;
            q_pc[0]     <= '0;
            q_pc[1]     <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= bus.imem_addr;
                fetch_pc    <= bus.imem_addr + 1'b1;
            end
            if (flush) begin
                count <= 2'd0;
            end else begin
                if (push) begin
                    q_inst[tail] <= bus.imem_data;
                    q_pc[tail]   <= inflight_pc;
                end
                head  <= head ^ pop;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end
endmodule
